// File: rtl/yutorina_mem_wb_stage_if.sv
// Pipeline-side and bus-side signals of the memory-access / write-back stage.
// The stage itself uses the master view (it masters the data bus and drives
// the register-file write port); the surrounding pipeline/bus uses slave.
interface yutorina_mem_wb_stage_if #(
    parameter int WORD_W     = 32,
    parameter int GPR_ADDR_W = 5
);
    // Execute-stage inputs and pipeline control
    logic                  ex_en;
    logic                  ex_gpr_we_;
    logic [GPR_ADDR_W-1:0] ex_dst_addr;
    logic [WORD_W-1:0]     ex_out;
    logic [1:0]            ex_mem_op;
    logic [WORD_W-1:0]     ex_st_data;
    logic                  stall;
    logic                  flush;
    logic                  busy;

    // CPU data bus
    logic                  bus_req;
    logic                  bus_rw;
    logic [WORD_W-3:0]     bus_addr;
    logic [WORD_W-1:0]     bus_wr_data;
    logic [WORD_W-1:0]     bus_rd_data;
    logic                  bus_rdy_;

    // Register-file write port and status pulses
    logic                  gpr_we_;
    logic [GPR_ADDR_W-1:0] gpr_w_addr;
    logic [WORD_W-1:0]     gpr_w_data;
    logic                  miss_align;
    logic                  bus_err;

    modport master (
        input  ex_en, ex_gpr_we_, ex_dst_addr, ex_out, ex_mem_op, ex_st_data,
        input  stall, flush, bus_rd_data, bus_rdy_,
        output busy, bus_req, bus_rw, bus_addr, bus_wr_data,
        output gpr_we_, gpr_w_addr, gpr_w_data, miss_align, bus_err
    );

    modport slave (
        output ex_en, ex_gpr_we_, ex_dst_addr, ex_out, ex_mem_op, ex_st_data,
        output stall, flush, bus_rd_data, bus_rdy_,
        input  busy, bus_req, bus_rw, bus_addr, bus_wr_data,
        input  gpr_we_, gpr_w_addr, gpr_w_data, miss_align, bus_err
    );
endinterface

// File: rtl/yutorina_mem_wb_stage.sv
// Memory-access / write-back stage: retires execute-stage results into the
// register file, runs word-aligned loads/stores on the data bus with a
// timeout, and holds the pipeline via busy while an access is outstanding.
module yutorina_mem_wb_stage #(
    parameter int WORD_W     = 32,
    parameter int GPR_ADDR_W = 5,
    parameter int TIMEOUT    = 255
) (
    input logic                    clk,
    input logic                    rst,
    yutorina_mem_wb_stage_if.master pipe
);
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    // Count value at which one more not-ready cycle means abort.
    localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

    state_t                state, state_nx;
    logic [7:0]            count, count_nx;
    logic [GPR_ADDR_W-1:0] ld_dst, ld_dst_nx;
    logic                  ld_we_, ld_we_nx;

    logic                  busy_nx, bus_req_nx, bus_rw_nx;
    logic [WORD_W-3:0]     bus_addr_nx;
    logic [WORD_W-1:0]     bus_wr_data_nx;
    logic                  gpr_we_nx;
    logic [GPR_ADDR_W-1:0] gpr_w_addr_nx;
    logic [WORD_W-1:0]     gpr_w_data_nx;
    logic                  miss_align_nx, bus_err_nx;

    logic accept;
    logic is_mem;

    assign accept = (state == IDLE) && pipe.ex_en && !pipe.stall && !pipe.flush;
    assign is_mem = (pipe.ex_mem_op == OP_LOAD) || (pipe.ex_mem_op == OP_STORE);

    // Next-state and next-output logic for the IDLE/ACCESS controller.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_nx       = state;
        count_nx       = count;
        ld_dst_nx      = ld_dst;
        ld_we_nx       = ld_we_;
        busy_nx        = pipe.busy;
        bus_req_nx     = pipe.bus_req;
        bus_rw_nx      = pipe.bus_rw;
        bus_addr_nx    = pipe.bus_addr;
        bus_wr_data_nx = pipe.bus_wr_data;
        gpr_we_nx      = 1'b1;
        gpr_w_addr_nx  = pipe.gpr_w_addr;
        gpr_w_data_nx  = pipe.gpr_w_data;
        miss_align_nx  = 1'b0;
        bus_err_nx     = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        // Plain ALU result (reserved op included): write back next cycle.
                        gpr_we_nx     = pipe.ex_gpr_we_;
                        gpr_w_addr_nx = pipe.ex_dst_addr;
                        gpr_w_data_nx = pipe.ex_out;
                    end else if (pipe.ex_out[1:0] != 2'b00) begin
                        miss_align_nx = 1'b1;
                    end else begin
                        state_nx       = ACCESS;
                        count_nx       = 8'd0;
                        busy_nx        = 1'b1;
                        bus_req_nx     = 1'b1;
                        bus_rw_nx      = (pipe.ex_mem_op == OP_LOAD);
                        bus_addr_nx    = pipe.ex_out[WORD_W-1:2];
                        bus_wr_data_nx = (pipe.ex_mem_op == OP_STORE) ? pipe.ex_st_data : '0;
                        ld_dst_nx      = pipe.ex_dst_addr;
                        ld_we_nx       = pipe.ex_gpr_we_;
                    end
                end
            end
            ACCESS: begin
                if (!pipe.bus_rdy_) begin
                    // Completion takes priority over a coincident timeout.
                    state_nx   = IDLE;
                    count_nx   = 8'd0;
                    busy_nx    = 1'b0;
                    bus_req_nx = 1'b0;
                    if (pipe.bus_rw && !ld_we_) begin
                        gpr_we_nx     = 1'b0;
                        gpr_w_addr_nx = ld_dst;
                        gpr_w_data_nx = pipe.bus_rd_data;
                    end
                end else if (count == COUNT_LAST) begin
                    state_nx   = IDLE;
                    count_nx   = 8'd0;
                    busy_nx    = 1'b0;
                    bus_req_nx = 1'b0;
                    bus_err_nx = 1'b1;
                end else begin
                    count_nx = count + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, latched load info and all registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state            <= IDLE;
            count            <= 8'd0;
            ld_dst           <= '0;
            ld_we_           <= 1'b1;
            pipe.busy        <= 1'b0;
            pipe.bus_req     <= 1'b0;
            pipe.bus_rw      <= 1'b1;
            pipe.bus_addr    <= '0;
            pipe.bus_wr_data <= '0;
            pipe.gpr_we_     <= 1'b1;
            pipe.gpr_w_addr  <= '0;
            pipe.gpr_w_data  <= '0;
            pipe.miss_align  <= 1'b0;
            pipe.bus_err     <= 1'b0;
        end else begin
            state            <= state_nx;
            count            <= count_nx;
            ld_dst           <= ld_dst_nx;
            ld_we_           <= ld_we_nx;
            pipe.busy        <= busy_nx;
            pipe.bus_req     <= bus_req_nx;
            pipe.bus_rw      <= bus_rw_nx;
            pipe.bus_addr    <= bus_addr_nx;
            pipe.bus_wr_data <= bus_wr_data_nx;
            pipe.gpr_we_     <= gpr_we_nx;
            pipe.gpr_w_addr  <= gpr_w_addr_nx;
            pipe.gpr_w_data  <= gpr_w_data_nx;
            pipe.miss_align  <= miss_align_nx;
            pipe.bus_err     <= bus_err_nx;
        end
    end
endmodule

// File: tb/tb_yutorina_mem_wb_stage.sv
// Directed bench for yutorina_mem_wb_stage. Expected register writes go into
// a scoreboard queue when the instruction is driven and are popped by a
// monitor whenever the stage pulses gpr_we_; bus and status signals are
// checked directly at each step. Built with TIMEOUT=4.
module tb_yutorina_mem_wb_stage;
    localparam int WORD_W     = 32;
    localparam int GPR_ADDR_W = 5;
    localparam int TIMEOUT    = 4;

    typedef struct {
        logic [GPR_ADDR_W-1:0] addr;
        logic [WORD_W-1:0]     data;
    } wb_t;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    wb_t  sb[$];

    yutorina_mem_wb_stage_if #(.WORD_W(WORD_W), .GPR_ADDR_W(GPR_ADDR_W)) pipe ();

    yutorina_mem_wb_stage #(
        .WORD_W    (WORD_W),
        .GPR_ADDR_W(GPR_ADDR_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pipe(pipe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe.ex_en       = 1'b0;
        pipe.ex_gpr_we_  = 1'b1;
        pipe.ex_dst_addr = '0;
        pipe.ex_out      = '0;
        pipe.ex_mem_op   = 2'd0;
        pipe.ex_st_data  = '0;
        pipe.stall       = 1'b0;
        pipe.flush       = 1'b0;
        pipe.bus_rd_data = '0;
        pipe.bus_rdy_    = 1'b1;
    endtask

    task automatic offer(input logic [1:0] op, input logic we_, input logic [4:0] dst,
                         input logic [31:0] out, input logic [31:0] st);
        pipe.ex_en       = 1'b1;
        pipe.ex_mem_op   = op;
        pipe.ex_gpr_we_  = we_;
        pipe.ex_dst_addr = dst;
        pipe.ex_out      = out;
        pipe.ex_st_data  = st;
    endtask

    task automatic expect_wb(input logic [4:0] a, input logic [31:0] d);
        wb_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every write pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && pipe.gpr_we_ === 1'b0) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", {27'd0, pipe.gpr_w_addr}, 32'hFFFF_FFFF);
            end else begin
                wb_t e;
                e = sb.pop_front();
                check("wb_addr", {27'd0, pipe.gpr_w_addr}, {27'd0, e.addr});
                check("wb_data", pipe.gpr_w_data, e.data);
            end
        end
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        // Reset state
        check("rst_gpr_we_", {31'd0, pipe.gpr_we_}, 32'd1);
        check("rst_gpr_w_addr", {27'd0, pipe.gpr_w_addr}, 32'd0);
        check("rst_gpr_w_data", pipe.gpr_w_data, 32'd0);
        check("rst_bus_req", {31'd0, pipe.bus_req}, 32'd0);
        check("rst_bus_rw", {31'd0, pipe.bus_rw}, 32'd1);
        check("rst_bus_addr", {2'd0, pipe.bus_addr}, 32'd0);
        check("rst_bus_wr_data", pipe.bus_wr_data, 32'd0);
        check("rst_busy", {31'd0, pipe.busy}, 32'd0);
        check("rst_miss_align", {31'd0, pipe.miss_align}, 32'd0);
        check("rst_bus_err", {31'd0, pipe.bus_err}, 32'd0);
        rst = 1'b0;
        tick();

        // NOP with write, latency 1
        offer(2'd0, 1'b0, 5'd5, 32'h1234_5678, 32'd0);
        expect_wb(5'd5, 32'h1234_5678);
        tick();
        idle_inputs();
        check("nop_we_", {31'd0, pipe.gpr_we_}, 32'd0);
        tick();
        check("nop_we_after", {31'd0, pipe.gpr_we_}, 32'd1);

        // NOP to r0 passes through; reserved op behaves as NOP
        offer(2'd3, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'd0);
        expect_wb(5'd0, 32'hDEAD_BEEF);
        tick();
        idle_inputs();
        check("rsv_bus_req", {31'd0, pipe.bus_req}, 32'd0);
        tick();

        // LOAD 0x100 -> r3, two wait cycles
        offer(2'd1, 1'b0, 5'd3, 32'h0000_0100, 32'd0);
        expect_wb(5'd3, 32'hCAFE_BABE);
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            check("ld_bus_req", {31'd0, pipe.bus_req}, 32'd1);
            check("ld_busy", {31'd0, pipe.busy}, 32'd1);
            check("ld_bus_addr", {2'd0, pipe.bus_addr}, 32'h40);
            check("ld_bus_rw", {31'd0, pipe.bus_rw}, 32'd1);
            if (i == 2) begin
                pipe.bus_rdy_    = 1'b0;
                pipe.bus_rd_data = 32'hCAFE_BABE;
            end
            tick();
        end
        idle_inputs();
        check("ld_done_req", {31'd0, pipe.bus_req}, 32'd0);
        check("ld_done_busy", {31'd0, pipe.busy}, 32'd0);
        check("ld_wb_we_", {31'd0, pipe.gpr_we_}, 32'd0);
        tick();
        check("ld_wb_once", {31'd0, pipe.gpr_we_}, 32'd1);

        // STORE 0x204: never writes back even with ex_gpr_we_=0
        offer(2'd2, 1'b0, 5'd9, 32'h0000_0204, 32'hA5A5_A5A5);
        tick();
        idle_inputs();
        check("st_bus_rw", {31'd0, pipe.bus_rw}, 32'd0);
        check("st_bus_addr", {2'd0, pipe.bus_addr}, 32'h81);
        check("st_wr_data", pipe.bus_wr_data, 32'hA5A5_A5A5);
        check("st_bus_req", {31'd0, pipe.bus_req}, 32'd1);
        pipe.bus_rdy_ = 1'b0;
        tick();
        idle_inputs();
        check("st_done_req", {31'd0, pipe.bus_req}, 32'd0);
        check("st_no_wb", {31'd0, pipe.gpr_we_}, 32'd1);
        tick();

        // Misaligned LOAD 0x102
        offer(2'd1, 1'b0, 5'd4, 32'h0000_0102, 32'd0);
        tick();
        idle_inputs();
        check("mis_pulse", {31'd0, pipe.miss_align}, 32'd1);
        check("mis_bus_req", {31'd0, pipe.bus_req}, 32'd0);
        check("mis_no_wb", {31'd0, pipe.gpr_we_}, 32'd1);
        tick();
        check("mis_pulse_end", {31'd0, pipe.miss_align}, 32'd0);
        check("mis_bus_req2", {31'd0, pipe.bus_req}, 32'd0);

        // Timeout: bus_rdy_ held high
        offer(2'd1, 1'b0, 5'd7, 32'h0000_0300, 32'd0);
        tick();
        idle_inputs();
        for (int i = 0; i < TIMEOUT; i++) begin
            check("to_bus_req", {31'd0, pipe.bus_req}, 32'd1);
            check("to_no_err", {31'd0, pipe.bus_err}, 32'd0);
            tick();
        end
        check("to_req_drop", {31'd0, pipe.bus_req}, 32'd0);
        check("to_bus_err", {31'd0, pipe.bus_err}, 32'd1);
        check("to_no_wb", {31'd0, pipe.gpr_we_}, 32'd1);
        tick();
        check("to_err_end", {31'd0, pipe.bus_err}, 32'd0);

        // Ready on the TIMEOUT-th cycle: completion wins
        offer(2'd1, 1'b0, 5'd9, 32'h0000_0304, 32'd0);
        expect_wb(5'd9, 32'h0BAD_F00D);
        tick();
        idle_inputs();
        for (int i = 0; i < TIMEOUT; i++) begin
            check("race_bus_req", {31'd0, pipe.bus_req}, 32'd1);
            if (i == TIMEOUT - 1) begin
                pipe.bus_rdy_    = 1'b0;
                pipe.bus_rd_data = 32'h0BAD_F00D;
            end
            tick();
        end
        idle_inputs();
        check("race_no_err", {31'd0, pipe.bus_err}, 32'd0);
        check("race_wb_we_", {31'd0, pipe.gpr_we_}, 32'd0);
        tick();

        // Back-to-back minimum-latency loads
        offer(2'd1, 1'b0, 5'd1, 32'h0000_0010, 32'd0);
        expect_wb(5'd1, 32'h1111_1111);
        tick();
        idle_inputs();
        pipe.bus_rdy_    = 1'b0;
        pipe.bus_rd_data = 32'h1111_1111;
        tick();
        idle_inputs();
        check("b2b_wb1", {31'd0, pipe.gpr_we_}, 32'd0);
        offer(2'd1, 1'b0, 5'd2, 32'h0000_0020, 32'd0);
        expect_wb(5'd2, 32'h2222_2222);
        tick();
        idle_inputs();
        check("b2b_req2", {31'd0, pipe.bus_req}, 32'd1);
        check("b2b_addr2", {2'd0, pipe.bus_addr}, 32'h08);
        // flush and stall during ACCESS have no effect
        pipe.flush       = 1'b1;
        pipe.stall       = 1'b1;
        pipe.bus_rdy_    = 1'b0;
        pipe.bus_rd_data = 32'h2222_2222;
        tick();
        idle_inputs();
        check("b2b_wb2", {31'd0, pipe.gpr_we_}, 32'd0);
        tick();

        // stall / flush block acceptance
        offer(2'd0, 1'b0, 5'd6, 32'h0000_0066, 32'd0);
        pipe.stall = 1'b1;
        tick();
        check("stall_no_wb", {31'd0, pipe.gpr_we_}, 32'd1);
        offer(2'd1, 1'b0, 5'd6, 32'h0000_0400, 32'd0);
        pipe.stall = 1'b0;
        pipe.flush = 1'b1;
        tick();
        idle_inputs();
        check("flush_no_req", {31'd0, pipe.bus_req}, 32'd0);
        check("flush_no_wb", {31'd0, pipe.gpr_we_}, 32'd1);
        tick();

        // Reset mid-ACCESS
        offer(2'd1, 1'b0, 5'd4, 32'h0000_0040, 32'd0);
        tick();
        idle_inputs();
        check("rma_req", {31'd0, pipe.bus_req}, 32'd1);
        rst = 1'b1;
        tick();
        check("rma_req_drop", {31'd0, pipe.bus_req}, 32'd0);
        check("rma_busy", {31'd0, pipe.busy}, 32'd0);
        check("rma_no_wb", {31'd0, pipe.gpr_we_}, 32'd1);
        check("rma_no_err", {31'd0, pipe.bus_err}, 32'd0);
        rst = 1'b0;
        tick();
        tick();

        check("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
